// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: data width, the receiver FSM state encoding
// (same encoding style as the transmitter) and the bit-period helper.
// No ports.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int bit_period(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
// Byte-side bundle of the UART receiver.
//   data_o      received byte, stable while valid_o=1
//   valid_o     holding register full
//   ready_i     consumer accepts data_o when valid_o & ready_i
//   frame_err_o one-cycle pulse: stop bit sampled 0
//   overrun_o   one-cycle pulse: completed byte dropped, holding register full
//   busy_o      receiver FSM not idle
// master: the receiver; slave: the consumer.
// ----------------------------------------------------------------------------
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] data_o;
    logic                   valid_o;
    logic                   ready_i;
    logic                   frame_err_o;
    logic                   overrun_o;
    logic                   busy_o;

    modport master (
        output data_o, valid_o, frame_err_o, overrun_o, busy_o,
        input  ready_i
    );

    modport slave (
        input  data_o, valid_o, frame_err_o, overrun_o, busy_o,
        output ready_i
    );

endinterface

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line. Resets to 1 (the
// idle line level) so reset never looks like a start bit.
//   clk  system clock
//   rst  synchronous active-high reset
//   d    asynchronous input
//   q    synchronized output
// ----------------------------------------------------------------------------
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: registered state uses non-blocking assignments so both flops
    // sample pre-edge values and the chain really is two stages deep.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first. Synchronizes rx_i, validates the start bit at
// mid-bit, shifts eight data bits, checks the stop bit and holds each good
// byte in a one-entry register under a valid/ready handshake.
//   clk     system clock
//   rst     synchronous active-high reset
//   rx_i    asynchronous serial line, idle high
//   rx_bus  uart_rx_if.master: data_o, valid_o, ready_i, frame_err_o,
//           overrun_o, busy_o
// Parameters: CLK_FREQ (Hz), BAUD_RATE (bit/s).
// Build option: UART_RX_MAJORITY_EN -- each start/data/stop decision is a
// 2-of-3 vote over the samples at point-1, point, point+1, taken one cycle
// after the nominal point.
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 1152000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    uart_rx_if.master  rx_bus
);

    localparam int          BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);
    localparam int          HALF       = BIT_PERIOD / 2;
    localparam logic [15:0] BIT_LAST   = 16'(BIT_PERIOD - 1);
`ifdef UART_RX_MAJORITY_EN
    // The vote needs point+1, so the start decision slips one cycle; the
    // whole frame then shifts with it and data/stop keep BIT_LAST.
    localparam logic [15:0] START_PT   = 16'(HALF);
`else
    localparam logic [15:0] START_PT   = 16'(HALF - 1);
`endif

    logic rx_s;
    logic rx_bit;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1, rx_d2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign rx_bit = (rx_d2 & rx_d1) | (rx_d2 & rx_s) | (rx_d1 & rx_s);
`else
    assign rx_bit = rx_s;
`endif

    rx_state_e              state, state_next;
    logic [15:0]            cnt, cnt_next;
    logic [2:0]             bit_idx, bit_idx_next;
    logic [UART_DATA_W-1:0] shift, shift_next;
    logic [UART_DATA_W-1:0] data_q;
    logic                   valid_q;
    logic                   ferr_q, ovr_q;
    logic                   load, ferr_set, ovr_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            ferr_q  <= ferr_set;
            ovr_q   <= ovr_set;
            // A reload in the accept cycle wins over the clear.
            if (load) begin
                data_q  <= shift;
                valid_q <= 1'b1;
            end else if (valid_q && rx_bus.ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // case can leave one unassigned and infer a latch.
        state_next   = state;
        cnt_next     = cnt + 16'd1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        load         = 1'b0;
        ferr_set     = 1'b0;
        ovr_set      = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                if (!rx_s) state_next = ST_START;
            end
            ST_START: begin
                if (cnt == START_PT) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    // A high line at mid-start is a glitch: drop silently.
                    state_next   = rx_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_bit, shift[UART_DATA_W-1:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_bit) begin
                        state_next = ST_IDLE;
                        if (!valid_q || rx_bus.ready_i) load    = 1'b1;
                        else                            ovr_set = 1'b1;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Held-low line: one frame error, then wait for idle.
                cnt_next = '0;
                if (rx_s) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rx_bus.data_o      = data_q;
    assign rx_bus.valid_o     = valid_q;
    assign rx_bus.frame_err_o = ferr_q;
    assign rx_bus.overrun_o   = ovr_q;
    assign rx_bus.busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at 87 clocks per bit. A table of single
// frames (consumer always ready) is followed by hand-written sequences for
// glitch rejection, held-low framing error, overrun, same-cycle reload and
// mid-frame reset.
// ----------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BP   = 87;
    localparam int SYNC = 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ  = 1;
`else
    localparam int MAJ  = 0;
`endif
    localparam int LAT  = 827 + MAJ;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rx_i  = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ  (100000000),
        .BAUD_RATE (1152000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (rx_i),
        .rx_bus (bus.master)
    );

    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_valid_rise = 0, n_valid_cyc = 0, n_ferr = 0, n_ovr = 0;
    int         last_valid_rise = -1, last_ferr = -1, last_ovr = -1;
    int         last_busy_fall = -1, stab_err = 0;
    logic [7:0] acc_q[$];
    logic       valid_prev = 1'b0, busy_prev = 1'b0, acc_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    always @(negedge clk) begin
        if (bus.valid_o && !valid_prev) begin
            n_valid_rise++;
            last_valid_rise = cyc;
        end
        if (bus.valid_o) n_valid_cyc++;
        if (valid_prev && bus.valid_o && !acc_prev && bus.data_o !== data_prev)
            stab_err++;
        if (bus.valid_o && bus.ready_i) acc_q.push_back(bus.data_o);
        if (bus.frame_err_o) begin
            n_ferr++;
            last_ferr = cyc;
        end
        if (bus.overrun_o) begin
            n_ovr++;
            last_ovr = cyc;
        end
        if (!bus.busy_o && busy_prev) last_busy_fall = cyc;
        acc_prev   = bus.valid_o && bus.ready_i;
        valid_prev = bus.valid_o;
        busy_prev  = bus.busy_o;
        data_prev  = bus.data_o;
    end

    // ---------------- helpers ----------------
    int total = 0;
    int bad   = 0;
    int last_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len);
        step();
        rx_i       = 1'b0;
        last_start = cyc;
        repeat (BP) step();
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (BP) step();
        end
        rx_i = stop_v;
        repeat (stop_len) step();
        rx_i = 1'b1;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    int a0, f0, o0, vc0, vr0, c0, e1, e2;

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[3] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'h81};
        vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C};

        bus.ready_i = 1'b0;
        rst         = 1'b1;
        rx_i        = 1'b1;
        repeat (4) step();
        check("rst data",  32'(bus.data_o),      32'h00);
        check("rst valid", 32'(bus.valid_o),     32'h0);
        check("rst busy",  32'(bus.busy_o),      32'h0);
        check("rst ferr",  32'(bus.frame_err_o), 32'h0);
        check("rst ovr",   32'(bus.overrun_o),   32'h0);
        rst = 1'b0;
        repeat (10) step();

        // ---- table: single frames, consumer always ready ----
        bus.ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a0  = acc_q.size();
            f0  = n_ferr;
            vc0 = n_valid_cyc;
            send_frame(vecs[i].data, vecs[i].stop, BP);
            repeat (10) step();
            check($sformatf("v%0d accepted", i), 32'(acc_q.size() - a0), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d ferr", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
            if (vecs[i].exp_valid && acc_q.size() > a0) begin
                check($sformatf("v%0d data", i), 32'(acc_q[a0]), 32'(vecs[i].exp_data));
                check($sformatf("v%0d valid time", i), 32'(last_valid_rise), 32'(last_start + SYNC + LAT));
                check($sformatf("v%0d valid width", i), 32'(n_valid_cyc - vc0), 32'd1);
            end
            if (vecs[i].exp_ferr)
                check($sformatf("v%0d ferr time", i), 32'(last_ferr), 32'(last_start + SYNC + LAT));
        end

        // ---- 20-cycle low glitch on idle line ----
        a0 = acc_q.size();
        f0 = n_ferr;
        step();
        rx_i = 1'b0;
        c0   = cyc;
        repeat (20) step();
        rx_i = 1'b1;
        repeat (100) step();
        check("glitch busy fall", 32'(last_busy_fall), 32'(c0 + SYNC + 44 + MAJ));
        check("glitch no valid",  32'(acc_q.size() - a0), 32'd0);
        check("glitch no ferr",   32'(n_ferr - f0), 32'd0);

        // ---- stop held low for two bits, then a good frame ----
        a0 = acc_q.size();
        f0 = n_ferr;
        send_frame(8'hA5, 1'b0, 2 * BP);
        repeat (20) step();
        check("break ferr count", 32'(n_ferr - f0), 32'd1);
        check("break ferr time",  32'(last_ferr), 32'(last_start + SYNC + LAT));
        check("break no valid",   32'(acc_q.size() - a0), 32'd0);
        send_frame(8'h3C, 1'b1, BP);
        repeat (10) step();
        check("after break count", 32'(acc_q.size() - a0), 32'd1);
        if (acc_q.size() > a0) check("after break data", 32'(acc_q[a0]), 32'h3C);

        // ---- overrun: back-to-back frames, consumer stalled ----
        bus.ready_i = 1'b0;
        a0  = acc_q.size();
        o0  = n_ovr;
        vr0 = n_valid_rise;
        send_frame(8'h48, 1'b1, BP);
        send_frame(8'h69, 1'b1, BP);
        check("ovr count",      32'(n_ovr - o0), 32'd1);
        check("ovr time",       32'(last_ovr), 32'(last_start + SYNC + LAT));
        check("ovr data held",  32'(bus.data_o), 32'h48);
        check("ovr valid held", 32'(bus.valid_o), 32'h1);
        bus.ready_i = 1'b1;
        step();
        step();
        check("ovr valid drop", 32'(bus.valid_o), 32'h0);
        repeat (50) step();
        check("ovr accepted count", 32'(acc_q.size() - a0), 32'd1);
        if (acc_q.size() > a0) check("ovr accepted data", 32'(acc_q[a0]), 32'h48);
        check("ovr valid rises", 32'(n_valid_rise - vr0), 32'd1);

        // ---- ready rises exactly in the second stop-sample cycle ----
        bus.ready_i = 1'b0;
        a0 = acc_q.size();
        o0 = n_ovr;
        c0 = cyc;
        e1 = c0 + 1;
        e2 = e1 + 10 * BP + 1;
        fork
            begin
                send_frame(8'h48, 1'b1, BP);
                send_frame(8'h69, 1'b1, BP);
            end
            begin
                wait_until(e2 + SYNC + LAT - 1);
                bus.ready_i = 1'b1;
            end
        join
        repeat (10) step();
        check("reload no ovr", 32'(n_ovr - o0), 32'd0);
        check("reload count",  32'(acc_q.size() - a0), 32'd2);
        if (acc_q.size() > a0 + 1) begin
            check("reload first",  32'(acc_q[a0]),     32'h48);
            check("reload second", 32'(acc_q[a0 + 1]), 32'h69);
        end
        check("reload valid drop", 32'(bus.valid_o), 32'h0);

        // ---- reset during data bit 4 of 0xF0 ----
        a0 = acc_q.size();
        f0 = n_ferr;
        c0 = cyc;
        fork
            send_frame(8'hF0, 1'b1, BP);
            begin
                wait_until(c0 + 1 + 5 * BP + 40);
                check("pre-rst busy", 32'(bus.busy_o), 32'h1);
                check("pre-rst data", 32'(bus.data_o), 32'h69);
                rst = 1'b1;
                step();
                check("mid rst data",  32'(bus.data_o),      32'h00);
                check("mid rst valid", 32'(bus.valid_o),     32'h0);
                check("mid rst busy",  32'(bus.busy_o),      32'h0);
                check("mid rst ferr",  32'(bus.frame_err_o), 32'h0);
                check("mid rst ovr",   32'(bus.overrun_o),   32'h0);
                rst = 1'b0;
            end
        join
        repeat (10) step();
        check("rst partial no valid", 32'(acc_q.size() - a0), 32'd0);
        check("rst partial no ferr",  32'(n_ferr - f0), 32'd0);
        send_frame(8'h0F, 1'b1, BP);
        repeat (10) step();
        check("post rst count", 32'(acc_q.size() - a0), 32'd1);
        check("post rst data",  32'(bus.data_o), 32'h0F);

        check("data stable while valid", 32'(stab_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
